// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding definitions for the instruction encoder: format codes,
// opcode constants, the request record and an immediate range helper.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // True when v equals the sign-extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] ext;
    ext = 32'($signed(v << (32 - bits)) >>> (32 - bits));
    return ext == v;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder. Both sides use strict
// valid/ready: a transfer happens on a rising edge where valid && ready, and a
// producer holds its payload stable while valid is high and ready is low.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational RV32I field packer: narrows the 32-bit immediate into the
// chosen format and flags immediates the format cannot represent.
module imm_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        range_err
);

  always_comb begin
    instr     = NOP_INSTR;
    range_err = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        instr     = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = !fits_signed(imm, 12);
      end
      FMT_S: begin
        instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = !fits_signed(imm, 12);
      end
      FMT_B: begin
        instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = !fits_signed(imm, 13) || imm[0];
      end
      FMT_U: begin
        instr     = {imm[31:12], rd, opcode};
        range_err = |imm[11:0];
      end
      FMT_J: begin
        instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = !fits_signed(imm, 21) || imm[0];
      end
      // Unknown formats become a harmless NOP, flagged as an error.
      default: begin
        instr     = NOP_INSTR;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with saturating word/error counters.
// Define ENC_DROP_ERR_EN to swallow erroneous words in stage 2 instead of emitting them.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  enc_req_t         s1_req_q, s1_req_d, in_req;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             s2_adv, accept, s1_to_s2, out_fire, enc_inc, err_inc;
  logic [31:0]      pack_instr;
  logic             pack_err;

  assign in_req = '{fmt: bus.in_fmt, opcode: bus.in_opcode, rd: bus.in_rd,
                    rs1: bus.in_rs1, rs2: bus.in_rs2, funct3: bus.in_funct3,
                    funct7: bus.in_funct7, imm: bus.in_imm};

  imm_pack u_pack (
    .fmt       (s1_req_q.fmt),
    .opcode    (s1_req_q.opcode),
    .rd        (s1_req_q.rd),
    .rs1       (s1_req_q.rs1),
    .rs2       (s1_req_q.rs2),
    .funct3    (s1_req_q.funct3),
    .funct7    (s1_req_q.funct7),
    .imm       (s1_req_q.imm),
    .instr     (pack_instr),
    .range_err (pack_err)
  );

  // Ready ripples backwards combinationally, so out_ready reaches in_ready in the same cycle.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s1_to_s2     = s1_valid_q && s2_adv;
  assign out_fire     = s2_valid_q && bus.out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_req_d   = in_req;
    end else if (s1_to_s2) begin
      s1_valid_d = 1'b0;
    end
    if (s2_adv) begin
`ifdef ENC_DROP_ERR_EN
      s2_valid_d = s1_valid_q && !pack_err;
      s2_err_d   = 1'b0;
`else
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_err_d = pack_err;
`endif
      if (s1_valid_q) s2_instr_d = pack_instr;
    end
  end

  always_comb begin
    enc_inc = out_fire;
`ifdef ENC_DROP_ERR_EN
    err_inc = s1_to_s2 && pack_err;
`else
    err_inc = out_fire && s2_err_q;
`endif
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (enc_inc && (enc_count_q != '1)) enc_count_d = enc_count_q + CNT_W'(1);
    if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign enc_count     = enc_count_q;
  assign err_count     = err_count_q;

endmodule
